// File: rtl/boot_loader.sv
// boot_loader: framed byte-stream loader feeding a RAM write port.
// A frame is a little-endian 32-bit base word address, a 32-bit word count
// and then the payload words. Each payload word becomes one single-cycle
// write strobe to consecutive word addresses.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds a trailing 4-byte XOR
// checksum to every frame and drives a sticky err flag; without it err is 0.
module boot_loader #(
  parameter int PBITS = 32,
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR_ADDR, ST_HDR_COUNT, ST_DATA, ST_WRITE, ST_SUM, ST_DONE
  } state_t;
  // Frames end with the checksum word.
  localparam state_t ST_TAIL = ST_SUM;
`else
  typedef enum logic [2:0] {
    ST_HDR_ADDR, ST_HDR_COUNT, ST_DATA, ST_WRITE, ST_DONE
  } state_t;
  // Frames end right after the last payload word.
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t            state_q;
  state_t            state_n;
  logic [1:0]        byte_cnt_q;
  // Holds the first three bytes of the word being collected, newest on top.
  logic [23:0]       shift_q;
  logic [31:0]       word_in;
  logic              accept;
  logic              last_byte;
  logic [PBITS-1:0]  addr_q;
  logic [31:0]       count_q;

  // The complete word as it stands once the byte on s_data is accepted.
  assign word_in   = {s_data, shift_q};
  assign accept    = s_valid && s_ready;
  assign last_byte = accept && (byte_cnt_q == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_HDR_ADDR;
    else          state_q <= state_n;
  end

  // Next-state decode and the combinational ready.
  always_comb begin
    state_n = state_q;
    s_ready = 1'b0;
    case (state_q)
      ST_HDR_ADDR: begin
        s_ready = 1'b1;
        if (last_byte) state_n = ST_HDR_COUNT;
      end
      ST_HDR_COUNT: begin
        s_ready = 1'b1;
        if (last_byte) state_n = (word_in == 32'd0) ? ST_TAIL : ST_DATA;
      end
      ST_DATA: begin
        s_ready = 1'b1;
        if (last_byte) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        state_n = (count_q == 32'd1) ? ST_TAIL : ST_DATA;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_SUM: begin
        s_ready = 1'b1;
        if (last_byte) state_n = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_n = ST_HDR_ADDR;
      end
      default: begin
        state_n = ST_HDR_ADDR;
      end
    endcase
  end

  // Byte collection, header registers, write strobe and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // The byte counter restarts whenever the state changes.
      if (state_n != state_q) byte_cnt_q <= 2'd0;
      else if (accept)        byte_cnt_q <= byte_cnt_q + 2'd1;

      if (accept) shift_q <= word_in[31:8];

      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done   <= (state_n == ST_DONE);

      if (state_q == ST_DONE) busy <= 1'b0;
      else if (accept)        busy <= 1'b1;

      case (state_q)
        ST_HDR_ADDR: begin
          if (last_byte) addr_q <= PBITS'(word_in);
        end
        ST_HDR_COUNT: begin
          if (last_byte) count_q <= word_in;
        end
        ST_DATA: begin
          // Issue the strobe on the same edge as the 4th byte so the
          // write occupies exactly the WRITE cycle.
          if (last_byte) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= addr_q;
            mem_data <= DBITS'(word_in);
          end
        end
        ST_WRITE: begin
          addr_q  <= addr_q + PBITS'(1);
          count_q <= count_q - 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running XOR over header and payload words; err latches the verdict.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
      err   <= 1'b0;
    end else begin
      if (accept && (state_q == ST_HDR_ADDR) && (byte_cnt_q == 2'd0)) err <= 1'b0;
      if (last_byte) begin
        case (state_q)
          ST_HDR_ADDR:           sum_q <= word_in;
          ST_HDR_COUNT, ST_DATA: sum_q <= sum_q ^ word_in;
          ST_SUM:                err   <= (word_in != sum_q);
          default: begin
          end
        endcase
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream memory loader sitting directly upstream of the dual-port RAM wrapper's port B. It parses a framed little-endian byte stream: a 32-bit base word address, a 32-bit word count, then payload words. Each payload word is written to consecutive word addresses via a single-cycle write strobe. Used at bring-up to fill program/data RAM from a UART or debug link before the core is released from reset.

## Interface
Parameters:
- `PBITS`, 32, width of the memory-side address
- `DBITS`, 32, memory data width; fixed at 32, since framing assembles 4 bytes per word

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  synchronous, active-low reset; sampled on rising `clk`
- `s_data`  in  8  stream byte
- `s_valid`  in  1  `s_data` is valid
- `s_ready`  out  1  loader accepts a byte this cycle
- `mem_addr`  out  PBITS  write word address (to port B `addrb`)
- `mem_data`  out  DBITS  write data (to `dinb`)
- `mem_en`  out  1  enable (to `enb`)
- `mem_we`  out  1  write enable (to `web`)
- `busy`  out  1  a frame is in progress (header or payload)
- `done`  out  1  one-cycle pulse at frame completion
- `err`  out  1  checksum mismatch on the last frame; sticky until the next frame starts (only with `BOOT_LOADER_CHECKSUM_EN`)

## Operation
- A byte is accepted on a rising edge when `s_valid && s_ready`. Bytes are little-endian: the first byte is bits [7:0].
- States: HDR_ADDR, HDR_COUNT, DATA, WRITE, SUM, DONE.
- HDR_ADDR: collect 4 bytes into the address register, then go to HDR_COUNT. Accepting the first byte clears `err` and sets `busy`.
- HDR_COUNT: collect 4 bytes into the count register.
  - Count 0: go to SUM if checksum is compiled in, else DONE.
  - Otherwise: go to DATA.
- DATA: collect 4 bytes into the word register. After the 4th byte, go to WRITE.
- WRITE (exactly 1 cycle): `mem_en=mem_we=1`, `mem_addr`=current address, `mem_data`=assembled word.
  - Address increments by 1, wrapping modulo 2^PBITS (0xFFFFFFFF → 0).
  - Count decrements by 1.
  - If the count reaches 0: go to SUM (checksum build) or DONE. Otherwise go back to DATA.
- SUM: collect 4 bytes. Compare them against the running XOR of the address word, the count word, and all payload words. Set `err` on mismatch, then go to DONE.
- DONE (1 cycle): `done=1`, `busy=0` next cycle, return to HDR_ADDR.
- The byte counter (0–3) is shared by all collecting states and resets to 0 on every state change.
- Reset (at any point, including mid-word or mid-frame):
  - state returns to HDR_ADDR; partial word, address, count and checksum are discarded;
  - all outputs read 0 except `s_ready=1`.
  - A RAM write already issued is not undone.

## Timing
- All outputs are registered except `s_ready`, which is a combinational decode of state: it is 1 in HDR_ADDR, HDR_COUNT, DATA and SUM, and 0 in WRITE and DONE.
- The 4th byte of a payload word is accepted at edge N. `mem_en`/`mem_we` are high for cycle N..N+1 only. The next byte can be accepted no earlier than edge N+2.
- `mem_en`/`mem_we` are never high in two consecutive cycles.
- When `mem_en=0`, `mem_addr` and `mem_data` hold their last values.
- Sustained throughput: 1 word per 5 cycles with `s_valid` held high.
- Last payload word accepted at edge N, no checksum: WRITE during N..N+1, `done` during N+1..N+2.
- Gaps with `s_valid=0` may occur anywhere; state holds.
- `s_data` is ignored whenever `s_ready=0`.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined:
  - the SUM state exists; every frame carries a trailing 4-byte XOR checksum;
  - `err` behaves as specified above.
- Not defined:
  - SUM and the checksum logic are omitted; frames end after the last payload word;
  - `err` is tied to 0.

## Test plan
- Reset held 3 cycles, then released → `s_ready=1`, `mem_en=mem_we=busy=done=err=0`.
- Frame with addr 0x00000100, count 2, words 0xDEADBEEF and 0x01234567, `s_valid` always high → writes (0x100, 0xDEADBEEF) then (0x101, 0x01234567); each strobe is 1 cycle with 4 idle cycles between; `done` pulses once.
- Count 0 frame → no `mem_en`; `done` pulses 1 cycle after the last count byte (plus the 4 checksum bytes if enabled).
- Address 0xFFFFFFFF, count 2 → writes to 0xFFFFFFFF, then 0x00000000.
- With `BOOT_LOADER_CHECKSUM_EN`:
  - correct checksum → `err=0`;
  - checksum with bit 0 flipped → `err=1` after `done`, cleared when the first byte of the next frame is accepted.
- `reset_n` low after 2 bytes of a payload word, then a fresh frame at addr 0x40, count 1, word 0xA5A5A5A5 → single write (0x40, 0xA5A5A5A5); no stale bytes appear.
